// File: rtl/max7219_ctrl.sv
// MAX7219 command sequencer: runs the power-up init sequence, then refreshes intensity/digits and shutdown on request.
// Latency: a command strobe follows its ISSUE decision by one cycle; back-to-back commands strobe the cycle after the previous ack.
// Backpressure: no strobe is issued while i_drv_busy is high; each command waits for i_drv_ack before the next one.
//
// Ports:
//   i_clk, i_reset_n        clock, asynchronous active-low reset
//   i_en                    display enable (low = shutdown)
//   i_refresh               single-cycle refresh request (collapses to one pending request)
//   i_intensity, i_digits   brightness nibble and segment bytes (digit k = i_digits[8k-1:8k-8])
//   o_stb, o_addr, o_data   command strobe and register address/data to the serial driver
//   i_drv_busy, i_drv_ack   driver transfer-in-progress and completion pulse
//   o_busy, o_done          sequence in progress; refresh-complete pulse
module max7219_ctrl #(
   parameter int          NUM_DIGITS  = 8,
   parameter logic [7:0]  DECODE_MODE = 8'h00
) (
   input  logic                    i_clk,
   input  logic                    i_reset_n,
   input  logic                    i_en,
   input  logic                    i_refresh,
   input  logic [3:0]              i_intensity,
   input  logic [8*NUM_DIGITS-1:0] i_digits,
   output logic                    o_stb,
   output logic [3:0]              o_addr,
   output logic [7:0]              o_data,
   input  logic                    i_drv_busy,
   input  logic                    i_drv_ack,
   output logic                    o_busy,
   output logic                    o_done
);

   typedef enum logic [2:0] {
      INIT_ISSUE,
      INIT_WAIT,
      IDLE,
      CMD_ISSUE,
      CMD_WAIT,
      DONE
   } state_t;

   state_t                  state_q;
   logic [3:0]              idx_q;
   logic                    stb_q;
   logic [3:0]              addr_q;
   logic [7:0]              data_q;
   logic                    done_q;
   logic                    pend_q;
   logic                    shut_q;      // last shutdown bit written to register C
   logic                    single_q;    // CMD_* states carry a lone shutdown command
   logic                    en_tgt_q;    // shutdown bit for that lone command
   logic [3:0]              int_q;       // intensity snapshot for the running refresh
   logic [8*NUM_DIGITS-1:0] digits_q;    // digit snapshot for the running refresh

   logic        in_init;
   logic [3:0]  last_idx;
   logic [11:0] cur_cmd;
   logic [11:0] nxt_cmd;

   // {addr, data} of command n in the active sequence.  Init commands read the
   // live inputs at issue time; refresh commands read the snapshot.
   function automatic logic [11:0] cmd_f(input logic init, input logic single,
                                         input logic [3:0] n);
      logic [11:0] c;
      c = 12'h000;
      if (init) begin
         case (n)
            4'd0:    c = {4'hF, 8'h00};
            4'd1:    c = {4'h9, DECODE_MODE};
            4'd2:    c = {4'hB, 8'(NUM_DIGITS - 1)};
            4'd3:    c = {4'hA, 4'h0, i_intensity};
            default: c = {4'hC, 7'h00, i_en};
         endcase
      end else if (single) begin
         c = {4'hC, 7'h00, en_tgt_q};
      end else if (n == 4'd0) begin
         c = {4'hA, 4'h0, int_q};
      end else begin
         c = {n, digits_q[(int'(n) - 1) * 8 +: 8]};
      end
      return c;
   endfunction

   assign in_init  = (state_q == INIT_ISSUE) || (state_q == INIT_WAIT);
   assign last_idx = in_init ? 4'd4 : (single_q ? 4'd0 : 4'(NUM_DIGITS));
   assign cur_cmd  = cmd_f(in_init, single_q, idx_q);
   assign nxt_cmd  = cmd_f(in_init, single_q, idx_q + 4'd1);

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q  <= INIT_ISSUE;
         idx_q    <= 4'd0;
         stb_q    <= 1'b0;
         addr_q   <= 4'h0;
         data_q   <= 8'h00;
         done_q   <= 1'b0;
         pend_q   <= 1'b0;
         shut_q   <= 1'b0;
         single_q <= 1'b0;
         en_tgt_q <= 1'b0;
         int_q    <= 4'h0;
         digits_q <= '0;
      end else begin
         stb_q  <= 1'b0;
         done_q <= 1'b0;
         // Any request is remembered; the flag is cleared below when a refresh starts.
         if (i_refresh) pend_q <= 1'b1;

         case (state_q)
            INIT_ISSUE, CMD_ISSUE: begin
               if (!i_drv_busy) begin
                  stb_q  <= 1'b1;
                  addr_q <= cur_cmd[11:8];
                  data_q <= cur_cmd[7:0];
                  if (cur_cmd[11:8] == 4'hC) shut_q <= cur_cmd[0];
                  state_q <= in_init ? INIT_WAIT : CMD_WAIT;
               end
            end

            INIT_WAIT, CMD_WAIT: begin
               if (i_drv_ack) begin
                  if (idx_q == last_idx) begin
                     if (in_init || single_q) begin
                        state_q <= IDLE;
                     end else begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                     end
                  end else begin
                     idx_q <= idx_q + 4'd1;
                     // Fast path: strobe the next command straight from WAIT so it
                     // lands the cycle after the ack; the stb_q guard keeps strobes apart.
                     if (!i_drv_busy && !stb_q) begin
                        stb_q  <= 1'b1;
                        addr_q <= nxt_cmd[11:8];
                        data_q <= nxt_cmd[7:0];
                        if (nxt_cmd[11:8] == 4'hC) shut_q <= nxt_cmd[0];
                     end else begin
                        state_q <= in_init ? INIT_ISSUE : CMD_ISSUE;
                     end
                  end
               end
            end

            IDLE: begin
               if (i_en != shut_q) begin
                  single_q <= 1'b1;
                  en_tgt_q <= i_en;
                  idx_q    <= 4'd0;
                  state_q  <= CMD_ISSUE;
               end else if ((pend_q || i_refresh) && shut_q) begin
                  // Refresh is held off while shut down; it stays pending until re-enable.
                  single_q <= 1'b0;
                  pend_q   <= 1'b0;
                  int_q    <= i_intensity;
                  digits_q <= i_digits;
                  idx_q    <= 4'd0;
                  state_q  <= CMD_ISSUE;
               end
            end

            DONE: begin
               state_q <= IDLE;
            end

            default: begin
               state_q <= INIT_ISSUE;
            end
         endcase
      end
   end

   assign o_stb  = stb_q;
   assign o_addr = addr_q;
   assign o_data = data_q;
   assign o_done = done_q;
   assign o_busy = (state_q != IDLE) && (state_q != DONE);

endmodule

// File: doc/max7219_ctrl.md
MAX7219_CTRL -- requirements
Module: max7219_ctrl

Interface
REQ-001 Parameter: NUM_DIGITS, default 8, number of digit registers refreshed (legal 1..8).
REQ-002 Parameter: DECODE_MODE, default 8'h00, value written to the decode-mode register (addr 4'h9).
REQ-003 Port: i_clk  input  1  system clock; all logic on rising edge.
REQ-004 Port: i_reset_n  input  1  asynchronous, active-low reset.
REQ-005 Port: i_en  input  1  display enable; high = normal operation, low = shutdown.
REQ-006 Port: i_refresh  input  1  single-cycle request to rewrite intensity and all digits.
REQ-007 Port: i_intensity  input  4  brightness for intensity register (addr 4'hA).
REQ-008 Port: i_digits  input  8*NUM_DIGITS  segment bytes; digit k (1-based) = i_digits[8k-1:8k-8].
REQ-009 Port: o_stb  output  1  command strobe to the serial driver.
REQ-010 Port: o_addr  output  4  command register address to the driver.
REQ-011 Port: o_data  output  8  command data to the driver.
REQ-012 Port: i_drv_busy  input  1  driver transfer in progress.
REQ-013 Port: i_drv_ack  input  1  driver single-cycle completion pulse.
REQ-014 Port: o_busy  output  1  high while any command sequence is in progress.
REQ-015 Port: o_done  output  1  single-cycle pulse when a refresh sequence completes.

Function
REQ-016 States SHALL be: INIT_ISSUE, INIT_WAIT, IDLE, CMD_ISSUE, CMD_WAIT, DONE.
REQ-017 Init sequence SHALL be, in order: (4'hF,8'h00) test off; (4'h9,DECODE_MODE); (4'hB,NUM_DIGITS-1); (4'hA,{4'h0,i_intensity}); (4'hC,{7'h0,i_en}).
REQ-018 Refresh sequence SHALL be: (4'hA,{4'h0,i_intensity}) then (k, digit k byte) for k = 1..NUM_DIGITS, ascending.
REQ-019 i_digits and i_intensity SHALL be snapshotted in the cycle the refresh sequence starts; later input changes do not alter that sequence.
REQ-020 ISSUE states: o_stb high for exactly one cycle, only when i_drv_busy is low; otherwise stay in ISSUE with o_stb low.
REQ-021 o_addr/o_data SHALL be valid in the o_stb cycle and held stable until the matching i_drv_ack.
REQ-022 WAIT states: advance on i_drv_ack high; the next command's o_stb is asserted on the following cycle if i_drv_busy is low.
REQ-023 A command index counter SHALL select the current command; it resets to 0 on each sequence start and must not wrap past the last command.
REQ-024 i_drv_ack seen outside a WAIT state SHALL be ignored.
REQ-025 IDLE priority: (1) i_en differs from last written shutdown bit -> single command (4'hC,{7'h0,i_en}), no o_done; (2) pending refresh -> refresh sequence; else remain IDLE.
REQ-026 i_refresh while not IDLE SHALL set one pending flag; multiple requests collapse to one; the flag clears when the refresh sequence starts.
REQ-027 i_refresh while i_en low SHALL remain pending and be serviced after re-enable command completes.
REQ-028 DONE lasts one cycle: o_done high, o_busy low, next state IDLE; entered only after the last refresh command's ack.
REQ-029 o_busy SHALL be high in all INIT_*, CMD_* states, low in IDLE and DONE.
REQ-030 o_stb SHALL never be high on two consecutive cycles.

Reset
REQ-031 While i_reset_n low: state INIT_ISSUE with index 0, o_stb=0, o_addr=0, o_data=0, o_done=0, o_busy=1, pending flag=0, stored shutdown bit=0.
REQ-032 Reset assertion mid-transfer SHALL abort immediately; after release the full init sequence restarts from command 0.

Verification
REQ-033 Release reset, i_en=1, i_intensity=4'h7, driver model 18-cycle transfer -> five strobes (F,00),(9,00),(B,07),(A,07),(C,01) in order, then IDLE, o_done never high.
REQ-034 After init, pulse i_refresh with i_digits=64'h0102030405060708 -> strobes (A,07),(1,08),(2,07)...(8,01), exactly one o_done pulse one cycle after the 9th ack.
REQ-035 Pulse i_refresh three times during an active refresh, change i_digits mid-sequence -> current sequence uses snapshot values, exactly one further refresh follows with new values.
REQ-036 Drop i_en in IDLE -> single command (C,00), no o_done; raise i_en with refresh pending -> (C,01) then full refresh.
REQ-037 Hold i_drv_busy high 10 cycles while in ISSUE -> o_stb stays low until busy falls, then one-cycle strobe.
REQ-038 Assert i_reset_n low during the 4th digit command -> outputs take reset values asynchronously; after release init restarts with (F,00).
